ram_dp: RTL and testbench
=========================

Name: ram_dp

Overview:
- Parametrised dual-port synchronous RAM; next-generation data/screen memory for the Hack CPU datapath.
- Port A: read/write, used by the CPU data bus. Port B: read-only, used by the screen/debug reader.
- Built-in clear engine zeroes the array after reset and on request.
- Synchronous read: one-cycle latency, with a valid strobe per port.

Parameters:
- DATA_W, 16, data word width in bits.
- ADDR_W, 15, address width in bits.
- DEPTH, 32768, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W.
- RDW_MODE, 0, same-address read-during-write result. 0 = old data (read-first), 1 = new data (write-first).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_n_i  input  1  reset, asynchronous, active-low.
- clear_i  input  1  one-cycle pulse; starts a full zeroing sweep.
- busy_o  output  1  high while the clear engine runs; all port accesses are ignored while high.
- a_en_i  input  1  port A access enable.
- a_we_i  input  1  port A write enable; qualified by a_en_i.
- a_addr_i  input  ADDR_W  port A address.
- a_data_i  input  DATA_W  port A write data.
- a_data_o  output  DATA_W  port A read data, registered.
- a_valid_o  output  1  port A read data valid, one-cycle pulse.
- b_en_i  input  1  port B read enable.
- b_addr_i  input  ADDR_W  port B address.
- b_data_o  output  DATA_W  port B read data, registered.
- b_valid_o  output  1  port B read data valid, one-cycle pulse.

Behaviour:
- Reset (rst_n_i low, asynchronous):
  - state=CLEAR, clear pointer=0, busy_o=1.
  - a_data_o=0, b_data_o=0, a_valid_o=0, b_valid_o=0.
  - Array contents are not reset by rst_n_i; only the clear engine zeroes them.
- FSM states:
  - CLEAR: each cycle writes 0 to mem[ptr] and increments ptr. At ptr==DEPTH-1, the write completes and the next state is IDLE, with busy_o=0 from the following cycle.
  - A sweep takes exactly DEPTH cycles after reset release or after the clear_i cycle.
  - IDLE: services ports. clear_i=1 -> next state CLEAR, ptr=0, busy_o=1 next cycle. The port access presented in the clear_i cycle is still performed.
  - clear_i during CLEAR: sweep restarts at ptr=0.
  - Reset mid-sweep: immediate restart per the reset rule.
- Port A, in IDLE:
  - a_en_i & a_we_i: mem[a_addr_i] <= a_data_i at the clock edge. a_valid_o=1 next cycle and a_data_o follows RDW_MODE: old word if 0, a_data_i if 1.
  - a_en_i & !a_we_i: a_data_o <= mem[a_addr_i], a_valid_o=1 next cycle.
  - !a_en_i: a_data_o holds its value, a_valid_o=0.
- Port B, in IDLE:
  - b_en_i: b_data_o <= mem[b_addr_i], b_valid_o=1 next cycle.
  - !b_en_i: b_data_o holds, b_valid_o=0.
- Collision: port A writes address X while port B reads X in the same cycle. b_data_o follows RDW_MODE (old word / new a_data_i); the write always lands.
- Out of range: address >= DEPTH. Writes are dropped; reads return 0 with valid asserted.
- While busy_o=1: a_en_i/b_en_i are ignored, valid outputs stay 0, data outputs hold.
- Fully pipelined: both ports accept a new access every cycle; no back-pressure apart from busy_o.
- Widths: no arithmetic on data. The clear pointer is ADDR_W+1 bits internally, so DEPTH=2**ADDR_W terminates without overflow.

Test Plan:
- Reset clear, DEPTH=16, ADDR_W=4. Release rst_n_i:
  - busy_o=1 for exactly 16 cycles, then 0.
  - Port B reads of addresses 0..15 all return 0x0000 with b_valid_o one cycle after b_en_i.
- Write/read latency:
  - A writes 0xBEEF to addr 5; next cycle A reads addr 5 -> a_data_o=0xBEEF, a_valid_o=1 exactly one cycle after the read request.
  - Back-to-back reads of addresses 5 and 6 return in consecutive cycles.
- Collision, addr 3 holds 0x1111. Same cycle: A writes 0x2222 to 3 and B reads 3:
  - RDW_MODE=0 -> b_data_o=0x1111.
  - RDW_MODE=1 -> b_data_o=0x2222.
  - Either mode: a following B read of 3 returns 0x2222.
- Clear request: after writing 0xAAAA everywhere, pulse clear_i:
  - busy_o high for 16 cycles.
  - Accesses issued during the sweep produce no valid pulse.
  - Afterwards every address reads 0.
- Reset mid-sweep: assert rst_n_i low at sweep cycle 7 and release:
  - Sweep restarts, busy_o=1 for a full 16 cycles.
  - Outputs are 0 during reset.
- Out of range, DEPTH=12, ADDR_W=4:
  - A write 0x5555 to addr 13 is dropped.
  - A read of addr 13 -> 0x0000 with valid.
  - Addr 1 (13 mod 12) is unchanged.

Source files
------------

// File: rtl/ram_dp.sv
// Dual-port synchronous RAM with a built-in zeroing sweep after reset or on request.
// Port A reads and writes, port B only reads. Both have registered outputs with a valid strobe.
//
// state    | meaning
// ST_CLEAR | sweep writes zero to mem[ptr]; port accesses are ignored
// ST_IDLE  | both ports are serviced; clear_i starts a new sweep
module ram_dp #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 15,
    parameter int DEPTH    = 32768,
    parameter int RDW_MODE = 0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clear_i,
    output logic              busy_o,
    input  logic              a_en_i,
    input  logic              a_we_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [DATA_W-1:0] a_data_i,
    output logic [DATA_W-1:0] a_data_o,
    output logic              a_valid_o,
    input  logic              b_en_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    output logic [DATA_W-1:0] b_data_o,
    output logic              b_valid_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] PTR_LAST = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ADDR_LIM = (ADDR_W+1)'(DEPTH);

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   ptr_q, ptr_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] a_data_q, a_data_d;
    logic              a_valid_q, a_valid_d;
    logic [DATA_W-1:0] b_data_q, b_data_d;
    logic              b_valid_q, b_valid_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic              a_in, b_in, collide;
    logic [DATA_W-1:0] a_rd, b_rd;

    // Addresses at or above DEPTH read as zero and never write.
    always_comb begin
        a_in    = ({1'b0, a_addr_i} < ADDR_LIM);
        b_in    = ({1'b0, b_addr_i} < ADDR_LIM);
        a_rd    = a_in ? mem_q[a_addr_i[IDX_W-1:0]] : '0;
        b_rd    = b_in ? mem_q[b_addr_i[IDX_W-1:0]] : '0;
        collide = a_en_i && a_we_i && a_in && b_in && (a_addr_i == b_addr_i);
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        busy_d    = busy_q;
        a_data_d  = a_data_q;
        a_valid_d = 1'b0;
        b_data_d  = b_data_q;
        b_valid_d = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = ptr_q[IDX_W-1:0];
        mem_wdata = '0;

        case (state_q)
            ST_CLEAR: begin
                mem_we = 1'b1;
                if (clear_i) begin
                    ptr_d = '0;
                end else if (ptr_q == PTR_LAST) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (a_en_i) begin
                    a_valid_d = 1'b1;
                    a_data_d  = (a_we_i && a_in && (RDW_MODE != 0)) ? a_data_i : a_rd;
                    if (a_we_i && a_in) begin
                        mem_we    = 1'b1;
                        mem_waddr = a_addr_i[IDX_W-1:0];
                        mem_wdata = a_data_i;
                    end
                end
                if (b_en_i) begin
                    b_valid_d = 1'b1;
                    b_data_d  = (collide && (RDW_MODE != 0)) ? a_data_i : b_rd;
                end
                // The access presented alongside clear_i has already been taken above.
                if (clear_i) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
                busy_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_CLEAR;
            ptr_q     <= '0;
            busy_q    <= 1'b1;
            a_data_q  <= '0;
            a_valid_q <= 1'b0;
            b_data_q  <= '0;
            b_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            busy_q    <= busy_d;
            a_data_q  <= a_data_d;
            a_valid_q <= a_valid_d;
            b_data_q  <= b_data_d;
            b_valid_q <= b_valid_d;
        end
    end

    // Array is left out of reset so it maps onto plain RAM; the sweep zeroes it.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign busy_o    = busy_q;
    assign a_data_o  = a_data_q;
    assign a_valid_o = a_valid_q;
    assign b_data_o  = b_data_q;
    assign b_valid_o = b_valid_q;

endmodule

// File: tb/tb_ram_dp.sv
// Directed bench for ram_dp: two DEPTH=16 instances (read-first / write-first)
// and one DEPTH=12 instance share stimulus; each step checks hand-computed values.
module tb_ram_dp;

    logic        clk = 1'b0;
    logic        rst_n, clear, a_en, a_we, b_en;
    logic [3:0]  a_addr, b_addr;
    logic [15:0] a_wdata;

    logic        busy0, busy1, busy2;
    logic [15:0] ad0, ad1, ad2, bd0, bd1, bd2;
    logic        av0, av1, av2, bv0, bv1, bv2;

    int vectors = 0;
    int errs    = 0;
    int cnt;

    always #5 clk = ~clk;

    ram_dp #(.DATA_W(16), .ADDR_W(4), .DEPTH(16), .RDW_MODE(0)) u0 (
        .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear), .busy_o(busy0),
        .a_en_i(a_en), .a_we_i(a_we), .a_addr_i(a_addr), .a_data_i(a_wdata),
        .a_data_o(ad0), .a_valid_o(av0),
        .b_en_i(b_en), .b_addr_i(b_addr), .b_data_o(bd0), .b_valid_o(bv0)
    );

    ram_dp #(.DATA_W(16), .ADDR_W(4), .DEPTH(16), .RDW_MODE(1)) u1 (
        .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear), .busy_o(busy1),
        .a_en_i(a_en), .a_we_i(a_we), .a_addr_i(a_addr), .a_data_i(a_wdata),
        .a_data_o(ad1), .a_valid_o(av1),
        .b_en_i(b_en), .b_addr_i(b_addr), .b_data_o(bd1), .b_valid_o(bv1)
    );

    ram_dp #(.DATA_W(16), .ADDR_W(4), .DEPTH(12), .RDW_MODE(0)) u2 (
        .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear), .busy_o(busy2),
        .a_en_i(a_en), .a_we_i(a_we), .a_addr_i(a_addr), .a_data_i(a_wdata),
        .a_data_o(ad2), .a_valid_o(av2),
        .b_en_i(b_en), .b_addr_i(b_addr), .b_data_o(bd2), .b_valid_o(bv2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        a_en  = 1'b0;
        a_we  = 1'b0;
        b_en  = 1'b0;
        clear = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        idle_in();
        a_addr  = '0;
        b_addr  = '0;
        a_wdata = '0;
        tick();
        tick();

        // reset state
        chk("rst_busy", busy0, 1);
        chk("rst_busy_rdw1", busy1, 1);
        chk("rst_adata", ad0, 0);
        chk("rst_bdata", bd0, 0);
        chk("rst_avalid", av0, 0);
        chk("rst_bvalid", bv0, 0);

        // release reset: sweep length
        rst_n = 1'b1;
        cnt = 0;
        while (busy0 && cnt < 100) begin
            tick();
            cnt++;
            if (cnt == 11) chk("d12_busy_on", busy2, 1);
            if (cnt == 12) chk("d12_busy_off", busy2, 0);
        end
        chk("rst_sweep_len", cnt, 16);
        chk("post_sweep_bvalid", bv0, 0);

        for (int i = 0; i < 16; i++) begin
            b_en   = 1'b1;
            b_addr = 4'(i);
            tick();
            chk("init_b_zero", bd0, 0);
            chk("init_b_valid", bv0, 1);
        end
        b_en = 1'b0;
        tick();
        chk("b_valid_drop", bv0, 0);

        // write / read latency
        a_en = 1'b1; a_we = 1'b1; a_addr = 4'd5; a_wdata = 16'hBEEF;
        tick();
        chk("wr5_valid", av0, 1);
        chk("wr5_valid_rdw1", av1, 1);
        chk("wr5_old", ad0, 16'h0000);
        chk("wr5_new", ad1, 16'hBEEF);
        a_addr = 4'd6; a_wdata = 16'h1234;
        tick();
        a_we = 1'b0; a_addr = 4'd5;
        tick();
        chk("rd5_data", ad0, 16'hBEEF);
        chk("rd5_valid", av0, 1);
        a_addr = 4'd6;
        tick();
        chk("rd6_data", ad0, 16'h1234);
        chk("rd6_valid", av0, 1);
        a_en = 1'b0;
        tick();
        chk("a_idle_valid", av0, 0);
        chk("a_idle_hold", ad0, 16'h1234);

        // collision on address 3
        a_en = 1'b1; a_we = 1'b1; a_addr = 4'd3; a_wdata = 16'h1111;
        tick();
        a_wdata = 16'h2222; b_en = 1'b1; b_addr = 4'd3;
        tick();
        chk("col_rdw0", bd0, 16'h1111);
        chk("col_rdw1", bd1, 16'h2222);
        chk("col_bvalid", bv0, 1);
        chk("col_bvalid_rdw1", bv1, 1);
        a_en = 1'b0; a_we = 1'b0;
        tick();
        chk("col_after_rdw0", bd0, 16'h2222);
        chk("col_after_rdw1", bd1, 16'h2222);
        b_en = 1'b0;

        // fill with AAAA, then clear request
        a_en = 1'b1; a_we = 1'b1; a_wdata = 16'hAAAA;
        for (int i = 0; i < 16; i++) begin
            a_addr = 4'(i);
            tick();
        end
        idle_in();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clrq_busy_on", busy0, 1);
        a_en = 1'b1; a_we = 1'b0; b_en = 1'b1; a_addr = 4'd7; b_addr = 4'd9;
        cnt = 0;
        while (busy0 && cnt < 100) begin
            chk("clrq_a_valid", av0, 0);
            chk("clrq_b_valid", bv0, 0);
            tick();
            cnt++;
        end
        chk("clrq_len", cnt, 16);
        chk("clrq_end_a_valid", av0, 0);
        chk("clrq_end_b_valid", bv0, 0);
        chk("clrq_hold", ad1, 16'hAAAA);
        a_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            b_en   = 1'b1;
            b_addr = 4'(i);
            tick();
            chk("clrq_zero", bd0, 0);
        end
        b_en = 1'b0;

        // reset in the middle of a sweep
        a_en = 1'b1; a_we = 1'b1; a_addr = 4'd2; a_wdata = 16'h7777;
        tick();
        a_we = 1'b0; b_en = 1'b1; b_addr = 4'd2;
        tick();
        chk("msw_pre_a", ad0, 16'h7777);
        chk("msw_pre_b", bd0, 16'h7777);
        idle_in();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (7) tick();
        chk("msw_hold", ad0, 16'h7777);
        chk("msw_busy", busy0, 1);
        rst_n = 1'b0;
        #1;
        chk("msw_rst_adata", ad0, 0);
        chk("msw_rst_bdata", bd0, 0);
        chk("msw_rst_avalid", av0, 0);
        chk("msw_rst_bvalid", bv0, 0);
        chk("msw_rst_busy", busy0, 1);
        tick();
        rst_n = 1'b1;
        cnt = 0;
        while (busy0 && cnt < 100) begin
            tick();
            cnt++;
        end
        chk("msw_len", cnt, 16);
        b_en = 1'b1; b_addr = 4'd2;
        tick();
        chk("msw_zero", bd0, 0);
        b_en = 1'b0;

        // out of range on the DEPTH=12 instance
        a_en = 1'b1; a_we = 1'b1; a_addr = 4'd1; a_wdata = 16'h3333;
        tick();
        a_addr = 4'd13; a_wdata = 16'h5555;
        tick();
        chk("oor_wr_valid", av2, 1);
        chk("oor_wr_data", ad2, 0);
        a_we = 1'b0;
        tick();
        chk("oor_rd_data", ad2, 0);
        chk("oor_rd_valid", av2, 1);
        chk("inr_rd13_d16", ad0, 16'h5555);
        a_en = 1'b0; b_en = 1'b1; b_addr = 4'd1;
        tick();
        chk("oor_alias", bd2, 16'h3333);
        b_addr = 4'd13;
        tick();
        chk("oor_b_data", bd2, 0);
        chk("oor_b_valid", bv2, 1);
        b_en = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
